// File: rtl/clock_divider_bank_pkg.sv
// rtl/clock_divider_bank_pkg.sv - shared constants and width helper for the game clock dividers
package clock_divider_pkg;

    localparam int CLK_HZ       = 100_000_000;
    localparam int HALF_1K_DEF  = 50_000;
    localparam int HALF_25_DEF  = 2_000_000;
    localparam int HALF_2P5_DEF = 20_000_000;

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clock_divider_bank_toggle_divider.sv
// rtl/clock_divider_bank_toggle_divider.sv - half-period counter plus toggle flop; tick port with DIV_STROBE_EN
module toggle_divider
    import clock_divider_pkg::*;
#(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic reset,
`ifdef DIV_STROBE_EN
    output logic tick,
`endif
    output logic out
);

    localparam int            W    = cnt_width(HALF);
    localparam logic [W-1:0]  LAST = W'(HALF - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         out_q, out_d;
    logic         wrap;

    always_comb begin
        wrap  = (cnt_q == LAST);
        cnt_d = cnt_q + 1'b1;
        out_d = out_q;
        if (wrap) begin
            cnt_d = '0;
            out_d = ~out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

`ifdef DIV_STROBE_EN
    logic tick_q, tick_d;

    // Strobe lands on the same edge the output goes 0->1.
    always_comb begin
        tick_d = wrap && !out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`endif

endmodule

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - 1000 Hz / 25 Hz / 2.5 Hz game clocks from 100 MHz; tick strobes with DIV_STROBE_EN
module clock_divider_bank
    import clock_divider_pkg::*;
#(
    parameter int HALF_1K  = HALF_1K_DEF,
    parameter int HALF_25  = HALF_25_DEF,
    parameter int HALF_2P5 = HALF_2P5_DEF
) (
    input  logic clk,
    input  logic reset,
`ifdef DIV_STROBE_EN
    output logic tick_1000hz,
    output logic tick_25hz,
    output logic tick_2p5hz,
`endif
    output logic clk_1000hz,
    output logic clk_25hz,
    output logic clk_2p5hz
);

    toggle_divider #(.HALF(HALF_1K)) u_div_1k (
        .clk   (clk),
        .reset (reset),
`ifdef DIV_STROBE_EN
        .tick  (tick_1000hz),
`endif
        .out   (clk_1000hz)
    );

    toggle_divider #(.HALF(HALF_25)) u_div_25 (
        .clk   (clk),
        .reset (reset),
`ifdef DIV_STROBE_EN
        .tick  (tick_25hz),
`endif
        .out   (clk_25hz)
    );

    toggle_divider #(.HALF(HALF_2P5)) u_div_2p5 (
        .clk   (clk),
        .reset (reset),
`ifdef DIV_STROBE_EN
        .tick  (tick_2p5hz),
`endif
        .out   (clk_2p5hz)
    );

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - self-checking bench for clock_divider_bank
module tb_clock_divider_bank;

    localparam int H1 = 2;
    localparam int H2 = 3;
    localparam int H3 = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic model_en = 1'b0;
    logic c1k, c25, c2p5, f1k, f25, f2p5;
`ifdef DIV_STROBE_EN
    logic t1k, t25, t2p5, u1k, u25, u2p5;
`endif

    int checks = 0;
    int errors = 0;
    int k = 0;

    always #5 clk = ~clk;

    clock_divider_bank #(.HALF_1K(H1), .HALF_25(H2), .HALF_2P5(H3)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef DIV_STROBE_EN
        .tick_1000hz(t1k),
        .tick_25hz  (t25),
        .tick_2p5hz (t2p5),
`endif
        .clk_1000hz (c1k),
        .clk_25hz   (c25),
        .clk_2p5hz  (c2p5)
    );

    clock_divider_bank #(.HALF_1K(1), .HALF_25(H2), .HALF_2P5(H3)) dut_fast (
        .clk        (clk),
        .reset      (reset),
`ifdef DIV_STROBE_EN
        .tick_1000hz(u1k),
        .tick_25hz  (u25),
        .tick_2p5hz (u2p5),
`endif
        .clk_1000hz (f1k),
        .clk_25hz   (f25),
        .clk_2p5hz  (f2p5)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // k = clk edges since the last edge that saw reset high.
    function automatic logic exp_out(input int n, input int h);
        return ((n / h) % 2) == 1;
    endfunction

    function automatic logic exp_tick(input int n, input int h);
        return (n > 0) && ((n % (2 * h)) == h);
    endfunction

    always @(posedge clk) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    always @(negedge clk) begin
        if (model_en) begin
            check_bit("model clk_1000hz", c1k, exp_out(k, H1));
            check_bit("model clk_25hz", c25, exp_out(k, H2));
            check_bit("model clk_2p5hz", c2p5, exp_out(k, H3));
            check_bit("model fast clk_1000hz", f1k, exp_out(k, 1));
`ifdef DIV_STROBE_EN
            check_bit("model tick_1000hz", t1k, exp_tick(k, H1));
            check_bit("model tick_25hz", t25, exp_tick(k, H2));
            check_bit("model tick_2p5hz", t2p5, exp_tick(k, H3));
            check_bit("model fast tick_1000hz", u1k, exp_tick(k, 1));
`endif
        end
    end

    initial begin
        logic [5:0] lit_1k, lit_25, lit_2p5, lit_fast;
        logic [2:0] cur, prev;
        int last_rise [3];
        int last_fall [3];
        int period [3];
        int high_len [3];
        int low_len [3];
        int halves [3];
        logic found, prev25, seen;
        int rise_at;
`ifdef DIV_STROBE_EN
        logic [5:0] lit_t25;
        lit_t25 = 6'b000100;
`endif
        // Bit i = expected value after release edge i+1.
        lit_1k   = 6'b100110;
        lit_25   = 6'b011100;
        lit_2p5  = 6'b110000;
        lit_fast = 6'b010101;
        halves[0] = H1; halves[1] = H2; halves[2] = H3;
        for (int c = 0; c < 3; c++) begin
            last_rise[c] = -1; last_fall[c] = -1;
            period[c] = -1; high_len[c] = -1; low_len[c] = -1;
        end

        reset = 1'b1;
        @(posedge clk);
        #1 model_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset clk_1000hz", c1k, 1'b0);
        check_bit("reset clk_25hz", c25, 1'b0);
        check_bit("reset clk_2p5hz", c2p5, 1'b0);
        check_bit("reset fast clk_1000hz", f1k, 1'b0);

        @(negedge clk) reset = 1'b0;
        prev = 3'b000;
        for (int i = 1; i <= 90; i++) begin
            @(posedge clk);
            #1;
            if (i <= 6) begin
                check_bit($sformatf("edge%0d clk_1000hz", i), c1k, lit_1k[i-1]);
                check_bit($sformatf("edge%0d clk_25hz", i), c25, lit_25[i-1]);
                check_bit($sformatf("edge%0d clk_2p5hz", i), c2p5, lit_2p5[i-1]);
                check_bit($sformatf("edge%0d fast clk_1000hz", i), f1k, lit_fast[i-1]);
`ifdef DIV_STROBE_EN
                check_bit($sformatf("edge%0d tick_25hz", i), t25, lit_t25[i-1]);
`endif
            end
            cur = {c2p5, c25, c1k};
            for (int c = 0; c < 3; c++) begin
                if (cur[c] && !prev[c]) begin
                    if (last_rise[c] >= 0) period[c] = i - last_rise[c];
                    if (last_fall[c] >= 0) low_len[c] = i - last_fall[c];
                    last_rise[c] = i;
                end else if (!cur[c] && prev[c]) begin
                    if (last_rise[c] >= 0) high_len[c] = i - last_rise[c];
                    last_fall[c] = i;
                end
            end
            prev = cur;
        end
        for (int c = 0; c < 3; c++) begin
            check_int($sformatf("period ch%0d", c), period[c], 2 * halves[c]);
            check_int($sformatf("high ch%0d", c), high_len[c], halves[c]);
            check_int($sformatf("low ch%0d", c), low_len[c], halves[c]);
        end

        // Reset mid-count: one edge after clk_25hz rises its counter sits at 1.
        found = 1'b0;
        prev25 = c25;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (c25 && !prev25) found = 1'b1;
            prev25 = c25;
        end
        check_bit("mid wait for clk_25hz rise", found, 1'b1);
        @(posedge clk);
        #1;
        check_bit("mid clk_25hz high before reset", c25, 1'b1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check_bit("mid reset clk_25hz", c25, 1'b0);
        check_bit("mid reset clk_1000hz", c1k, 1'b0);
        check_bit("mid reset clk_2p5hz", c2p5, 1'b0);
        @(negedge clk) reset = 1'b0;
        seen = 1'b0;
        rise_at = -1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (c25 && !seen) begin
                seen = 1'b1;
                rise_at = n;
            end
        end
        check_int("mid rise edge after release", rise_at, 3);

        repeat (20) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Derives the three slow game clocks from the 100 MHz board clock: 1000 Hz for random-number stepping, 25 Hz for sprite and scroll animation, and 2.5 Hz for the score counter.
- Each output is a registered, 50 %-duty square wave produced by a half-period counter and a toggle flop.
- Sits at the top of the game next to the VGA sync block. Its outputs feed the score, goose, bean and floor logic.

Parameters:
- HALF_1K, 50_000, input-clock cycles per half period of clk_1000hz (100 MHz / (2×1000)).
- HALF_25, 2_000_000, input-clock cycles per half period of clk_25hz.
- HALF_2P5, 20_000_000, input-clock cycles per half period of clk_2p5hz.
- All three must be ≥ 1.
- Each counter width is $clog2(HALF_x), with a minimum of 1 bit.

Ports:
- clk  input  1  board clock, 100 MHz.
- reset  input  1  synchronous, active-high.
- clk_1000hz  output  1  1000 Hz square wave, 50 % duty.
- clk_25hz  output  1  25 Hz square wave, 50 % duty.
- clk_2p5hz  output  1  2.5 Hz square wave, 50 % duty.
- tick_1000hz, tick_25hz, tick_2p5hz  output  1 each  single-cycle strobes; present only with DIV_STROBE_EN.

Behaviour:
- Three independent channels, identical logic, differing only in the HALF_x parameter.
- All state updates on posedge clk.
- Reset:
  - When reset=1 at an edge, every counter becomes 0 and every clk_* output becomes 0.
  - Reset has priority over counting on the same edge.
  - A reset mid-operation discards the partial count; there is no glitch beyond that registered clear.
- Counting, per channel:
  - If cnt == HALF_x−1, then cnt ← 0 and out ← ~out.
  - Otherwise cnt ← cnt+1 and out holds.
- Timing:
  - After reset deasserts, the first rising edge of out is registered on the HALF_x-th clk edge.
  - The full period is exactly 2·HALF_x clk cycles, with high and low each lasting HALF_x cycles.
- HALF_x = 1 gives a clk/2 output that toggles every cycle.
- Outputs come directly from flops with no combinational path, so they are safe to use as downstream fabric clocks.
- Channels run free and are not phase-aligned to each other beyond the common reset release.
- Counters never exceed HALF_x−1, so there is no wrap-around hazard.

Optional Feature:
- Macro: DIV_STROBE_EN.
- Defined:
  - Adds the three tick_* outputs.
  - Each tick is registered and is 1 for exactly one clk cycle on the same edge its channel's out goes 0→1, i.e. once per full period.
  - Ticks are 0 during and immediately after reset.
- Undefined: the tick ports and their logic are absent, and the clk_* behaviour is unchanged.

Decomposition:
- Shared package clock_divider_pkg holds:
  - CLK_HZ = 100_000_000.
  - The three default half-period constants.
  - A width helper function returning max(1, $clog2(n)).
- One sub-module, toggle_divider, with:
  - Parameter HALF.
  - Ports clk, reset, out, and tick under the macro.
- It is instantiated three times in clock_divider_bank.

Test Plan:
- HALF_1K=2, HALF_25=3, HALF_2P5=5, with reset held for 4 cycles then released:
  - All outputs are 0 during reset.
  - clk_1000hz rises on edge 2 after release and falls on edge 4.
  - clk_25hz rises on edge 3 after release.
  - clk_2p5hz rises on edge 5 after release.
- Same parameters, run 100 cycles: clk_2p5hz period measures exactly 10 cycles, high 5 and low 5; the other channels measure 4 and 6 cycles.
- Assert reset for 1 cycle while clk_25hz=1 with cnt mid-count:
  - The next edge gives output 0.
  - The following rise occurs exactly 3 edges after release.
- HALF_1K=1: clk_1000hz toggles every clk edge after reset.
- With DIV_STROBE_EN and HALF_25=3: tick_25hz is high for 1 cycle, coincident with each clk_25hz rise, giving 1 pulse per 6 cycles.
- Default parameters, 100 MHz clock: clk_1000hz shows 1.000 ms period and clk_25hz shows 40 ms period in a long simulation.
